// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch address generation and the IF/ID pipeline register.
// Optional fetch/bubble performance counters are enabled with the IF_PERF_CNT_EN macro.
module if_stage #(
    parameter int            N        = 32,
    parameter logic [N-1:0]  RESET_PC = 32'd0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         freeze,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_addr,
    input  logic         flush,
    output logic [N-1:0] imem_pc,
    input  logic [N-1:0] imem_instruction,
    output logic [N-1:0] pc_out,
    output logic [N-1:0] instruction_out,
    output logic         valid_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]  fetch_count,
    output logic [31:0]  bubble_count
`endif
);

    localparam logic [N-1:0] ZERO_W = {N{1'b0}};
    localparam logic [N-1:0] FOUR_W = {{(N-3){1'b0}}, 3'd4};

    // Instructions are word aligned; low address bits are always discarded.
    function automatic logic [N-1:0] word_align(input logic [N-1:0] addr);
        logic [N-1:0] res;
        res      = addr;
        res[1:0] = 2'b00;
        return res;
    endfunction

    logic [N-1:0] pc_r;
    logic [N-1:0] pc_plus4_s;
    logic         bubble_s;

    assign imem_pc    = word_align(pc_r);
    assign pc_plus4_s = imem_pc + FOUR_W;
    assign bubble_s   = branch_taken | flush;

    // PC register: redirect beats stall, otherwise advance by one word (wraps modulo 2^N).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (branch_taken) begin
            pc_r <= word_align(branch_addr);
        end else if (freeze) begin
            pc_r <= pc_r;
        end else begin
            pc_r <= pc_plus4_s;
        end
    end

    // IF/ID register: a redirect or flush inserts a bubble; zero data is legal, valid_out marks bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out          <= ZERO_W;
            instruction_out <= ZERO_W;
            valid_out       <= 1'b0;
        end else if (bubble_s) begin
            pc_out          <= ZERO_W;
            instruction_out <= ZERO_W;
            valid_out       <= 1'b0;
        end else if (freeze) begin
            pc_out          <= pc_out;
            instruction_out <= instruction_out;
            valid_out       <= valid_out;
        end else begin
            pc_out          <= pc_plus4_s;
            instruction_out <= imem_instruction;
            valid_out       <= 1'b1;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Performance counters: one event per IF/ID load, nothing counted while frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count  <= 32'd0;
            bubble_count <= 32'd0;
        end else if (bubble_s) begin
            fetch_count  <= fetch_count;
            bubble_count <= bubble_count + 32'd1;
        end else if (freeze) begin
            fetch_count  <= fetch_count;
            bubble_count <= bubble_count;
        end else begin
            fetch_count  <= fetch_count + 32'd1;
            bubble_count <= bubble_count;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic against a cycle model.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        flush;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_pcout;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [31:0] m_fc;
    logic [31:0] m_bc;

    if_stage #(.N(32), .RESET_PC(32'd0)) dut (
        .clk              (clk),
        .rst              (rst),
        .freeze           (freeze),
        .branch_taken     (branch_taken),
        .branch_addr      (branch_addr),
        .flush            (flush),
        .imem_pc          (imem_pc),
        .imem_instruction (imem_instruction),
        .pc_out           (pc_out),
        .instruction_out  (instruction_out),
        .valid_out        (valid_out)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count      (fetch_count),
        .bubble_count     (bubble_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the byte address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'd0) return 32'hE3A0_0014;
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    assign imem_instruction = mem(imem_pc);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        check("imem_pc", imem_pc, m_pc & 32'hFFFF_FFFC);
        check("pc_out", pc_out, m_pcout);
        check("instruction_out", instruction_out, m_instr);
        check("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
`ifdef IF_PERF_CNT_EN
        check("fetch_count", fetch_count, m_fc);
        check("bubble_count", bubble_count, m_bc);
`endif
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_pcout = 32'd0; m_instr = 32'd0; m_valid = 1'b0;
        m_fc = 32'd0; m_bc = 32'd0;
    endtask

    task automatic drive(input logic b, input logic [31:0] a, input logic f, input logic fl);
        branch_taken = b; branch_addr = a; freeze = f; flush = fl;
    endtask

    // One clock edge: advance the model from the inputs present at the edge, then compare.
    task automatic tick();
        logic [31:0] fetch;
        @(posedge clk);
        fetch = m_pc & 32'hFFFF_FFFC;
        if (branch_taken || flush) begin
            m_pcout = 32'd0; m_instr = 32'd0; m_valid = 1'b0; m_bc = m_bc + 32'd1;
        end else if (!freeze) begin
            m_pcout = fetch + 32'd4; m_instr = mem(fetch); m_valid = 1'b1; m_fc = m_fc + 32'd1;
        end
        if (branch_taken) m_pc = branch_addr & 32'hFFFF_FFFC;
        else if (!freeze) m_pc = fetch + 32'd4;
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        model_reset();
        #12;
        check_model();
        @(negedge clk);
        rst = 1'b0;

        // sequential fetch from RESET_PC
        tick();
        check("seq pc_out 4", pc_out, 32'd4);
        check("seq instr", instruction_out, 32'hE3A0_0014);
        check("seq valid", {31'd0, valid_out}, 32'd1);
        tick(); check("seq pc_out 8", pc_out, 32'd8);
        tick(); check("seq pc_out 12", pc_out, 32'd12);
        tick(); check("seq pc_out 16", pc_out, 32'd16);

        // redirect from 144 to 112
        drive(1'b1, 32'd144, 1'b0, 1'b0); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);   tick();
        check("redir fetch144", pc_out, 32'd148);
        drive(1'b1, 32'd112, 1'b0, 1'b0); tick();
        check("redir imem_pc", imem_pc, 32'd112);
        check("redir bubble valid", {31'd0, valid_out}, 32'd0);
        check("redir bubble instr", instruction_out, 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0);   tick();
        check("redir pc_out", pc_out, 32'd116);

        // stall at PC=40 for three cycles
        drive(1'b1, 32'd36, 1'b0, 1'b0); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);  tick();
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall imem_pc", imem_pc, 32'd40);
            check("stall pc_out", pc_out, 32'd40);
            check("stall instr", instruction_out, mem(32'd36));
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0); tick();
        check("stall release", pc_out, 32'd44);

        // branch wins over freeze; flush alone
        drive(1'b1, 32'h103, 1'b1, 1'b0); tick();
        check("br+frz pc", imem_pc, 32'h100);
        check("br+frz valid", {31'd0, valid_out}, 32'd0);
        drive(1'b1, 32'd20, 1'b0, 1'b0); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b1);  tick();
        check("flush valid", {31'd0, valid_out}, 32'd0);
        check("flush pc", imem_pc, 32'd24);

        // wrap at top of address space
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0); tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0); tick();
        check("wrap pc_out", pc_out, 32'd0);
        check("wrap imem_pc", imem_pc, 32'd0);

        // async reset between edges
        #2;
        rst = 1'b1;
        #1;
        check("async pc_out", pc_out, 32'd0);
        check("async valid", {31'd0, valid_out}, 32'd0);
        check("async imem_pc", imem_pc, 32'd0);
        model_reset();
        check_model();
        @(negedge clk);
        rst = 1'b0;

`ifdef IF_PERF_CNT_EN
        // counters: 5 fetches, 1 branch, 2 frozen cycles
        for (int i = 0; i < 5; i++) tick();
        drive(1'b1, 32'd64, 1'b0, 1'b0); tick();
        drive(1'b0, 32'd0, 1'b1, 1'b0); tick(); tick();
        check("cnt fetch", fetch_count, 32'd5);
        check("cnt bubble", bubble_count, 32'd1);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
`endif

        // randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 9) == 0)
                branch_addr = {$urandom_range(0, 1) == 1 ? 16'hFFFF : 16'h0000, 16'($urandom)};
            tick();
            if ($urandom_range(0, 49) == 0) begin
                #2;
                do_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter N, default 32, the datapath width of PC and instruction.
REQ-002 The block SHALL have parameter RESET_PC, default 32'd0, the PC value loaded on reset.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the asynchronous, active-high reset.
REQ-005 The block SHALL have port freeze, input, 1, the hazard stall: hold PC and IF/ID.
REQ-006 The block SHALL have port branch_taken, input, 1, the redirect request from downstream.
REQ-007 The block SHALL have port branch_addr, input, N, the redirect target byte address.
REQ-008 The block SHALL have port flush, input, 1, which kills the IF/ID contents without redirecting.
REQ-009 The block SHALL have port imem_pc, output, N, the fetch address driven to instruction memory.
REQ-010 The block SHALL have port imem_instruction, input, N, the combinational instruction returned for imem_pc.
REQ-011 The block SHALL have port pc_out, output, N, the registered PC+4 of the fetched instruction.
REQ-012 The block SHALL have port instruction_out, output, N, the registered instruction.
REQ-013 The block SHALL have port valid_out, output, 1, which is high when IF/ID holds a real instruction.

Function
REQ-014 The block SHALL drive imem_pc combinationally from the PC register, with bits [1:0] forced to 2'b00.
REQ-015 The block SHALL update the PC each clk edge in priority order: branch_taken gives branch_addr with [1:0] cleared; else freeze holds; else PC+4.
REQ-016 The block SHALL compute PC+4 modulo 2^N, so 0xFFFFFFFC advances to 0x00000000 with no error flag.
REQ-017 The block SHALL update IF/ID each edge in priority order: branch_taken or flush loads 0 into pc_out and instruction_out and 0 into valid_out; else freeze holds; else it loads PC+4, imem_instruction, and valid_out=1.
REQ-018 The block SHALL have a fetch-to-IF/ID latency of exactly one cycle, and pc_out SHALL equal the fetch address + 4.
REQ-019 When branch_taken and freeze are both high, the block SHALL redirect the PC and bubble IF/ID; branch_taken wins.
REQ-020 When flush is high without branch_taken, the block SHALL bubble IF/ID, and the PC SHALL follow freeze/increment normally.
REQ-021 When freeze is held for K cycles, the block SHALL keep all outputs constant for K cycles, then resume at the held PC.
REQ-022 The encoding 32'd0 SHALL be treated as data; valid_out alone marks bubbles.

Reset
REQ-023 While rst is high, the block SHALL set PC=RESET_PC, pc_out=0, instruction_out=0 and valid_out=0 immediately, independent of clk.
REQ-024 After rst deasserts, the first rising edge SHALL load IF/ID from RESET_PC, and reset mid-stall or mid-branch SHALL discard the pending action.

Configuration
REQ-025 With macro IF_PERF_CNT_EN defined, the block SHALL add outputs fetch_count[31:0] and bubble_count[31:0]. Their behaviour SHALL be:
  - both reset to 0;
  - fetch_count increments on each edge that loads valid_out=1;
  - bubble_count increments on each edge that loads valid_out=0 through branch_taken or flush;
  - both wrap modulo 2^32 and hold under freeze.
REQ-026 Without IF_PERF_CNT_EN, the block SHALL contain neither these ports nor the counter logic, and all other behaviour SHALL be identical.

Verification
REQ-027 The bench SHALL cover sequential fetch: rst pulse, memory returns 0xE3A00014 at address 0 -> after the first edge pc_out=4, instruction_out=0xE3A00014, valid_out=1; then pc_out 8, 12, 16 on the next edges.
REQ-028 The bench SHALL cover redirect: fetch at 144, then branch_taken=1 with branch_addr=112 for one cycle -> next imem_pc=112, IF/ID bubble (valid_out=0, instruction_out=0), next edge pc_out=116.
REQ-029 The bench SHALL cover stall: freeze=1 for 3 cycles at PC=40 -> imem_pc stays 40 and pc_out/instruction_out are unchanged; after release pc_out=44.
REQ-030 The bench SHALL cover simultaneous events: freeze=1 and branch_taken=1 with branch_addr=0x103 -> PC=0x100 and valid_out=0; flush alone at PC=20 -> bubble and PC=24.
REQ-031 The bench SHALL cover wrap and async reset: branch to 0xFFFFFFFC -> next pc_out=0x00000000. Assert rst between clock edges -> outputs go to 0 and PC to RESET_PC before the next edge.
REQ-032 The bench SHALL cover counters (IF_PERF_CNT_EN): 5 fetches, 1 branch, 2 frozen cycles -> fetch_count=5, bubble_count=1.
